// File: rtl/fft_pkg.sv
// Shared types and defaults for the FFT frame sequencer.
package fft_pkg;

    localparam int          FFT_SIZE_DEF = 4096;
    localparam int          IDX_W        = $clog2(FFT_SIZE_DEF);
    localparam logic [15:0] CFG_WORD_DEF = 16'h0001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CFG  = 2'd1,
        RUN  = 2'd2,
        PAD  = 2'd3
    } fsm_state_t;

endpackage

// File: rtl/sample_fifo.sv
// Small synchronous sample buffer. A push while full is accepted only when a
// pop happens in the same cycle, so a full FIFO can stream at one per cycle.
module sample_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         push,
    input  logic [W-1:0] wr_data,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         push_ok;
    logic         pop_ok;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign head    = mem[rd_ptr[AW-1:0]];

    // Pointer update; the extra MSB distinguishes full from empty.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk_in) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/fft_frame_ctrl.sv
// Sequencer between the audio sample source and the FFT core: configures the
// core, frames buffered samples with tlast, zero-pads on stop, and tracks the
// bin index on the core's output stream.
//
// Handshake rule on every stream: a beat transfers on a clock edge where valid
// and ready are both high; once valid is raised, valid and data hold steady
// until that transfer, and ready may change freely.
module fft_frame_ctrl
    import fft_pkg::*;
#(
    parameter int          FFT_SIZE   = FFT_SIZE_DEF,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [15:0] CFG_WORD   = CFG_WORD_DEF
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        enable_in,
    input  logic                        clear_in,
    input  logic [7:0]                  sample_in,
    input  logic                        sample_valid_in,
    output logic [15:0]                 cfg_tdata_out,
    output logic                        cfg_tvalid_out,
    input  logic                        cfg_tready_in,
    output logic [15:0]                 fft_tdata_out,
    output logic                        fft_tvalid_out,
    output logic                        fft_tlast_out,
    input  logic                        fft_tready_in,
    input  logic                        bin_tvalid_in,
    input  logic                        bin_tlast_in,
    output logic                        bin_tready_out,
    input  logic                        consumer_ready_in,
    output logic [$clog2(FFT_SIZE)-1:0] bin_index_out,
    output logic                        frame_in_done_out,
    output logic                        frame_out_done_out,
    output logic                        overflow_out,
    output logic                        misalign_out,
    output logic                        busy_out,
    output logic [1:0]                  state_dbg_out
);

    localparam int             IW       = $clog2(FFT_SIZE);
    localparam logic [IW-1:0]  LAST_IDX = IW'(FFT_SIZE - 1);

    fsm_state_t    state;
    logic [IW-1:0] sample_cnt;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    fifo_head;
    logic          fft_hs;
    logic          pad_done;
    logic          overflow_set;
    logic          bin_hs;
    logic          bin_at_last;
    logic          misalign_set;

    sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (8)
    ) u_fifo (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .push    (fifo_push),
        .wr_data (sample_in),
        .pop     (fifo_pop),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head    (fifo_head)
    );

    // Input side: FIFO head drives the core; PAD emits zeros once the FIFO drains.
    // A PAD cycle with count 0 and an empty FIFO means the frame is already closed.
    assign pad_done       = (sample_cnt == '0) && fifo_empty;
    assign fifo_push      = (state == RUN) && sample_valid_in;
    assign fft_tvalid_out = ((state == RUN) && !fifo_empty) || ((state == PAD) && !pad_done);
    assign fft_tdata_out  = fifo_empty ? 16'h0000 : {8'h00, fifo_head};
    assign fft_tlast_out  = (sample_cnt == LAST_IDX) && fft_tvalid_out;
    assign fft_hs         = fft_tvalid_out && fft_tready_in;
    assign fifo_pop       = fft_hs && !fifo_empty;
    assign overflow_set   = fifo_push && fifo_full && !fifo_pop;

    // Output side: bins are discarded while idle so in-flight frames drain.
    assign bin_tready_out = (state == IDLE) ? 1'b1 : consumer_ready_in;
    assign bin_hs         = bin_tvalid_in && bin_tready_out;
    assign bin_at_last    = (bin_index_out == LAST_IDX);
    assign misalign_set   = bin_hs && (bin_tlast_in != bin_at_last);

    assign busy_out       = (state != IDLE);
    assign state_dbg_out  = state;

    // Control FSM with registered config-channel outputs.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state          <= IDLE;
            cfg_tvalid_out <= 1'b0;
            cfg_tdata_out  <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    if (enable_in) begin
                        state          <= CFG;
                        cfg_tvalid_out <= 1'b1;
                        cfg_tdata_out  <= CFG_WORD;
                    end
                end
                CFG: begin
                    if (cfg_tready_in) begin
                        cfg_tvalid_out <= 1'b0;
                        cfg_tdata_out  <= 16'h0000;
                        state          <= enable_in ? RUN : IDLE;
                    end
                end
                RUN: begin
                    if (!enable_in) state <= pad_done ? IDLE : PAD;
                end
                PAD: begin
                    if ((fft_hs && fft_tlast_out && fifo_empty) || pad_done) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Position within the current input frame plus the frame-complete pulse.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            sample_cnt        <= '0;
            frame_in_done_out <= 1'b0;
        end else begin
            frame_in_done_out <= fft_hs && fft_tlast_out;
            if (fft_hs) sample_cnt <= (sample_cnt == LAST_IDX) ? '0 : sample_cnt + 1'b1;
        end
    end

    // Sticky overflow; a new drop in the clear cycle keeps the flag set.
    always_ff @(posedge clk_in) begin
        if (!rst_in)           overflow_out <= 1'b0;
        else if (overflow_set) overflow_out <= 1'b1;
        else if (clear_in)     overflow_out <= 1'b0;
    end

    // Bin index tracking; core tlast realigns the index to zero.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            bin_index_out      <= '0;
            frame_out_done_out <= 1'b0;
        end else begin
            frame_out_done_out <= bin_hs && bin_tlast_in;
            if (bin_hs) bin_index_out <= (bin_tlast_in || bin_at_last) ? '0 : bin_index_out + 1'b1;
        end
    end

    // Sticky misalignment between core tlast and the tracked index.
    always_ff @(posedge clk_in) begin
        if (!rst_in)           misalign_out <= 1'b0;
        else if (misalign_set) misalign_out <= 1'b1;
        else if (clear_in)     misalign_out <= 1'b0;
    end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed bench for fft_frame_ctrl: config handshake, framing, backpressure,
// zero padding, bin tracking and reset abort.
module tb_fft_frame_ctrl;
    import fft_pkg::*;

    localparam int FFT_N = 4096;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        enable_in;
    logic        clear_in;
    logic [7:0]  sample_in;
    logic        sample_valid_in;
    logic [15:0] cfg_tdata_out;
    logic        cfg_tvalid_out;
    logic        cfg_tready_in;
    logic [15:0] fft_tdata_out;
    logic        fft_tvalid_out;
    logic        fft_tlast_out;
    logic        fft_tready_in;
    logic        bin_tvalid_in;
    logic        bin_tlast_in;
    logic        bin_tready_out;
    logic        consumer_ready_in;
    logic [11:0] bin_index_out;
    logic        frame_in_done_out;
    logic        frame_out_done_out;
    logic        overflow_out;
    logic        misalign_out;
    logic        busy_out;
    logic [1:0]  state_dbg_out;

    // clock/reset block
    always #5 clk_in = ~clk_in;

    fft_frame_ctrl dut (
        .clk_in             (clk_in),
        .rst_in             (rst_in),
        .enable_in          (enable_in),
        .clear_in           (clear_in),
        .sample_in          (sample_in),
        .sample_valid_in    (sample_valid_in),
        .cfg_tdata_out      (cfg_tdata_out),
        .cfg_tvalid_out     (cfg_tvalid_out),
        .cfg_tready_in      (cfg_tready_in),
        .fft_tdata_out      (fft_tdata_out),
        .fft_tvalid_out     (fft_tvalid_out),
        .fft_tlast_out      (fft_tlast_out),
        .fft_tready_in      (fft_tready_in),
        .bin_tvalid_in      (bin_tvalid_in),
        .bin_tlast_in       (bin_tlast_in),
        .bin_tready_out     (bin_tready_out),
        .consumer_ready_in  (consumer_ready_in),
        .bin_index_out      (bin_index_out),
        .frame_in_done_out  (frame_in_done_out),
        .frame_out_done_out (frame_out_done_out),
        .overflow_out       (overflow_out),
        .misalign_out       (misalign_out),
        .busy_out           (busy_out),
        .state_dbg_out      (state_dbg_out)
    );

    // scoreboard state
    logic [7:0] exp_q[$];
    int n_vec     = 0;
    int n_miss    = 0;
    int hs_cnt    = 0;
    int last_cnt  = 0;
    int last_at   = 0;
    int fin_done  = 0;
    int fout_done = 0;
    int frame_pos = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // One clock: score the data handshake about to happen, then count pulses.
    task automatic step();
        logic [15:0] exp_d;
        if (fft_tvalid_out && fft_tready_in) begin
            exp_d = 16'h0000;
            if (exp_q.size() != 0) exp_d = {8'h00, exp_q.pop_front()};
            chk("fft_tdata", 32'(fft_tdata_out), 32'(exp_d));
            chk("fft_tlast", 32'(fft_tlast_out), 32'(frame_pos == FFT_N - 1));
            hs_cnt++;
            if (fft_tlast_out) begin
                last_cnt++;
                last_at = hs_cnt;
            end
            frame_pos = (frame_pos == FFT_N - 1) ? 0 : frame_pos + 1;
        end
        @(posedge clk_in);
        #1;
        if (frame_in_done_out)  fin_done++;
        if (frame_out_done_out) fout_done++;
    endtask

    task automatic clr_counts();
        hs_cnt   = 0;
        last_cnt = 0;
        last_at  = 0;
        fin_done = 0;
        fout_done = 0;
    endtask

    // driver: one sample strobe, optionally expected at the core input
    task automatic push_sample(input logic [7:0] s, input bit accepted);
        sample_valid_in = 1'b1;
        sample_in       = s;
        if (accepted) exp_q.push_back(s);
        step();
        sample_valid_in = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        int cyc;
        rst_in = 1'b0; enable_in = 1'b0; clear_in = 1'b0;
        sample_in = 8'h00; sample_valid_in = 1'b0; cfg_tready_in = 1'b0;
        fft_tready_in = 1'b0; bin_tvalid_in = 1'b0; bin_tlast_in = 1'b0;
        consumer_ready_in = 1'b0;
        step(); step();

        // reset state
        chk("rst_fft_tvalid", 32'(fft_tvalid_out), 32'd0);
        chk("rst_cfg_tvalid", 32'(cfg_tvalid_out), 32'd0);
        chk("rst_fft_tdata",  32'(fft_tdata_out),  32'd0);
        chk("rst_cfg_tdata",  32'(cfg_tdata_out),  32'd0);
        chk("rst_busy",       32'(busy_out),       32'd0);
        chk("rst_bin_index",  32'(bin_index_out),  32'd0);
        chk("rst_flags",      32'({overflow_out, misalign_out, frame_in_done_out, frame_out_done_out}), 32'd0);
        chk("rst_bin_tready", 32'(bin_tready_out), 32'd1);

        // startup: config held 6 cycles, handshake on the 6th
        rst_in = 1'b1; enable_in = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("cfg_tvalid_hold", 32'(cfg_tvalid_out), 32'd1);
            chk("cfg_tdata_hold",  32'(cfg_tdata_out),  32'h0001);
            step();
        end
        chk("cfg_tvalid_6", 32'(cfg_tvalid_out), 32'd1);
        cfg_tready_in = 1'b1;
        step();
        cfg_tready_in = 1'b0;
        chk("cfg_done_state", 32'(state_dbg_out), 32'(RUN));
        chk("cfg_tvalid_off", 32'(cfg_tvalid_out), 32'd0);

        // full frame of 0..255 repeating
        fft_tready_in = 1'b1;
        clr_counts();
        for (int i = 0; i < FFT_N; i++) begin
            if (i == 254) chk("sample_neg3", 32'(fft_tdata_out), 32'h00FD);
            push_sample(i[7:0], 1'b1);
        end
        step(); step();
        chk("frame_hs",       32'(hs_cnt),   32'd4096);
        chk("frame_tlast_n",  32'(last_cnt), 32'd1);
        chk("frame_tlast_at", 32'(last_at),  32'd4096);
        chk("frame_in_done",  32'(fin_done), 32'd1);
        chk("frame_overflow", 32'(overflow_out), 32'd0);
        chk("frame_drained",  32'(fft_tvalid_out), 32'd0);

        // backpressure: 16 buffered, 17th dropped
        fft_tready_in = 1'b0;
        clr_counts();
        for (int k = 0; k < 17; k++) push_sample(8'(8'h10 + k), k < 16);
        chk("bp_overflow", 32'(overflow_out), 32'd1);
        chk("bp_head",     32'(fft_tdata_out), 32'h0010);
        fft_tready_in = 1'b1;
        for (int k = 0; k < 17; k++) step();
        chk("bp_hs",       32'(hs_cnt), 32'd16);
        chk("bp_q_empty",  32'(exp_q.size()), 32'd0);
        chk("bp_drained",  32'(fft_tvalid_out), 32'd0);
        clear_in = 1'b1;
        step();
        clear_in = 1'b0;
        chk("bp_clear", 32'(overflow_out), 32'd0);

        // stop after 100 samples: 3996 zeros then idle
        for (int k = 0; k < 84; k++) push_sample(8'(k * 3 + 1), 1'b1);
        step();
        clr_counts();
        enable_in = 1'b0;
        step();
        chk("pad_state", 32'(state_dbg_out), 32'(PAD));
        cyc = 0;
        while (busy_out && cyc < 5000) begin
            step();
            cyc++;
        end
        chk("pad_busy",    32'(busy_out), 32'd0);
        chk("pad_hs",      32'(hs_cnt),   32'd3996);
        chk("pad_tlast_n", 32'(last_cnt), 32'd1);
        chk("pad_done",    32'(fin_done), 32'd1);
        chk("pad_state_idle", 32'(state_dbg_out), 32'(IDLE));

        // output side: restart and stream 4096 bins with toggling consumer ready
        enable_in = 1'b1;
        step();
        cfg_tready_in = 1'b1;
        step();
        cfg_tready_in = 1'b0;
        chk("run2_state", 32'(state_dbg_out), 32'(RUN));
        clr_counts();
        sent = 0;
        cyc  = 0;
        while (sent < FFT_N && cyc < 12000) begin
            consumer_ready_in = cyc[0];
            bin_tvalid_in     = 1'b1;
            bin_tlast_in      = (sent == FFT_N - 1);
            #1;
            if (cyc < 4) chk("bin_tready_gate", 32'(bin_tready_out), 32'(consumer_ready_in));
            if (consumer_ready_in) begin
                chk("bin_index", 32'(bin_index_out), 32'(sent));
                sent++;
            end
            step();
            cyc++;
        end
        bin_tvalid_in = 1'b0; bin_tlast_in = 1'b0;
        step();
        chk("bin_sent",      32'(sent),          32'd4096);
        chk("bin_out_done",  32'(fout_done),     32'd1);
        chk("bin_misalign",  32'(misalign_out),  32'd0);
        chk("bin_index_end", 32'(bin_index_out), 32'd0);

        // early tlast at bin 10
        clr_counts();
        consumer_ready_in = 1'b1;
        for (int k = 0; k < 11; k++) begin
            bin_tvalid_in = 1'b1;
            bin_tlast_in  = (k == 10);
            step();
        end
        bin_tvalid_in = 1'b0; bin_tlast_in = 1'b0;
        step();
        chk("early_misalign", 32'(misalign_out),  32'd1);
        chk("early_index",    32'(bin_index_out), 32'd0);
        chk("early_done",     32'(fout_done),     32'd1);

        // clear in the same cycle as a new misalign event: set wins
        clear_in = 1'b1; bin_tvalid_in = 1'b1; bin_tlast_in = 1'b1;
        step();
        clear_in = 1'b0; bin_tvalid_in = 1'b0; bin_tlast_in = 1'b0;
        chk("clear_vs_set", 32'(misalign_out), 32'd1);
        clear_in = 1'b1;
        step();
        clear_in = 1'b0;
        chk("misalign_clear", 32'(misalign_out), 32'd0);

        // reset mid-run with 5 samples buffered and count at 5
        fft_tready_in = 1'b1;
        for (int k = 0; k < 5; k++) push_sample(8'(8'hA0 + k), 1'b1);
        step();
        fft_tready_in = 1'b0;
        for (int k = 0; k < 5; k++) push_sample(8'(8'hB0 + k), 1'b1);
        chk("pre_rst_tvalid", 32'(fft_tvalid_out), 32'd1);
        rst_in = 1'b0;
        step();
        chk("post_rst_tvalid", 32'(fft_tvalid_out), 32'd0);
        chk("post_rst_busy",   32'(busy_out),       32'd0);
        chk("post_rst_state",  32'(state_dbg_out),  32'(IDLE));
        exp_q.delete();
        frame_pos = 0;
        rst_in = 1'b1;
        step();
        cfg_tready_in = 1'b1;
        step();
        cfg_tready_in = 1'b0;
        fft_tready_in = 1'b1;
        clr_counts();
        for (int i = 0; i < FFT_N; i++) push_sample(8'(i * 7), 1'b1);
        step(); step();
        chk("rst_count_tlast_at", 32'(last_at),  32'd4096);
        chk("rst_count_tlast_n",  32'(last_cnt), 32'd1);
        chk("rst_count_done",     32'(fin_done), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/fft_frame_ctrl.md
Name: fft_frame_ctrl

Overview:
Sequencer between the audio sample source and the 4096-point FFT core.
- Configures the core once per start via its config AXI-stream.
- Buffers incoming 8-bit samples in a small FIFO and frames them onto the core's data AXI-stream with tlast on every FFT_SIZE-th sample.
- Zero-pads a partial frame on stop.
- Gates the core's output stream to a downstream bin consumer while tracking bin index and frame alignment.

Parameters:
FFT_SIZE, 4096, points per frame; power of two.
FIFO_DEPTH, 16, sample buffer entries; power of two, ≥2.
CFG_WORD, 16'h0001, value sent on config channel (forward transform, default scaling).

Ports:
clk_in  in  1  system clock
rst_in  in  1  synchronous reset, active-low
enable_in  in  1  level; high = run, low = stop after current frame
clear_in  in  1  pulse; clears sticky flags
sample_in  in  8  signed audio sample
sample_valid_in  in  1  one-cycle strobe; no backpressure to source
cfg_tdata_out  out  16  core config data
cfg_tvalid_out  out  1  core config valid
cfg_tready_in  in  1  core config ready
fft_tdata_out  out  16  core input; [7:0]=real sample, [15:8]=imag=0
fft_tvalid_out  out  1  core input valid
fft_tlast_out  out  1  last sample of frame
fft_tready_in  in  1  core input ready
bin_tvalid_in  in  1  core output valid
bin_tlast_in  in  1  core output last
bin_tready_out  out  1  ready to core output; = consumer_ready_in when state != IDLE, else 1
consumer_ready_in  in  1  downstream bin consumer ready
bin_index_out  out  $clog2(FFT_SIZE)  index of bin currently on core output
frame_in_done_out  out  1  pulse: frame's last sample handshaken
frame_out_done_out  out  1  pulse: last bin handshaken
overflow_out  out  1  sticky: sample dropped on full FIFO
misalign_out  out  1  sticky: bin_tlast_in disagrees with bin_index_out==FFT_SIZE-1
busy_out  out  1  state != IDLE

Behaviour:
- Reset (rst_in==0 at clk edge): state=IDLE, FIFO empty, sample count=0, bin index=0. All valid/last/pulse/sticky outputs 0; data outputs 0. The core shares rst_in and is reset with this block.
- States: IDLE, CFG, RUN, PAD.
- IDLE -> CFG when enable_in==1. In CFG: cfg_tvalid_out=1, cfg_tdata_out=CFG_WORD, held until cfg_tready_in. On that handshake go to RUN if enable_in, else IDLE. The handshake always completes even if enable drops during CFG.
- Samples are pushed only in RUN. In IDLE, CFG and PAD, sample_valid_in is ignored and not flagged.
- Push: sample written into FIFO on the sample_valid_in cycle. Earliest appearance on fft_tvalid_out is the next cycle.
- FIFO head drives fft_tdata_out: imag byte 0, real byte = sample unchanged.
- fft_tvalid_out = FIFO non-empty (RUN) or pad active (PAD). fft_tvalid_out and fft_tdata_out stay stable until fft_tready_in.
- Sample count increments on each data handshake and wraps FFT_SIZE-1 -> 0.
- fft_tlast_out = (count==FFT_SIZE-1) && fft_tvalid_out.
- frame_in_done_out pulses for 1 cycle, the cycle after the tlast handshake.
- Full FIFO with push and pop in the same cycle: both occur, no overflow. Full FIFO with push and no pop: sample dropped, overflow_out set.
- RUN with enable_in==0:
  - count==0 and FIFO empty -> IDLE.
  - else -> PAD. In PAD the FIFO drains first, then zeros are emitted until the tlast handshake, then IDLE.
- Output side:
  - Bin handshake = bin_tvalid_in && bin_tready_out.
  - bin_index_out increments on each bin handshake and wraps at FFT_SIZE-1.
  - On handshake with bin_tlast_in==1, bin_index forces to 0 (realign) and frame_out_done_out pulses next cycle.
  - misalign_out is set on any bin handshake where bin_tlast_in != (index==FFT_SIZE-1).
  - Output tracking continues in IDLE so in-flight frames drain; bin_tready_out=1 in IDLE discards bins.
- clear_in clears overflow_out and misalign_out. A set event in the same cycle wins.
- Reset mid-frame aborts everything; no pad is emitted.

Decomposition:
- fft_pkg: state enum (IDLE, CFG, RUN, PAD), localparam IDX_W=$clog2(FFT_SIZE), default CFG_WORD.
- One sub-module: sample_fifo. Synchronous, FIFO_DEPTH entries, 8-bit, same active-low reset. Ports: push, pop, full, empty, head data; simultaneous push/pop allowed when full.

Test Plan:
- Startup: release reset, enable_in=1, cfg_tready_in=0 for 5 cycles then 1 -> cfg_tvalid_out held 6 cycles with 16'h0001, one handshake, state RUN.
- Full frame: 4096 samples 0..255 repeating, fft_tready_in=1 -> 4096 handshakes, tlast only on 4096th, frame_in_done_out one pulse, overflow_out=0. Sample -3 appears as fft_tdata_out=16'h00FD.
- Backpressure: fft_tready_in=0 while 17 samples arrive -> first 16 buffered, 17th dropped, overflow_out=1. Release -> 16 samples out in order. clear_in -> overflow_out=0.
- Stop mid-frame: enable_in=0 after 100 samples handshaken -> 3996 zero samples, tlast on final, then IDLE, busy_out=0.
- Output: drive 4096 bins with consumer_ready_in toggling -> bin_index_out 0..4095, frame_out_done_out one pulse, misalign_out=0. Repeat with bin_tlast_in at bin 10 -> misalign_out=1 and index back to 0.
- Reset: rst_in low for 1 cycle mid-RUN with FIFO holding 5 samples -> next cycle fft_tvalid_out=0, busy_out=0, count 0.
